// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger launcher slice.
package trigger_pkg;

    // Launcher FSM states, 3-bit encoded
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DELAY   = 3'd1,
        ASSERT  = 3'd2,
        RELEASE = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    localparam int TRIG_COUNT_W    = 16;
    localparam int SYNC_STAGES_DEF = 2;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [TRIG_COUNT_W-1:0] sat_inc(input logic [TRIG_COUNT_W-1:0] v);
        logic [TRIG_COUNT_W-1:0] res;
        if (v == {TRIG_COUNT_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + TRIG_COUNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/trigger_launcher_if.sv
// Launch-request / trigger bundle between a requester and the launcher.
interface trigger_launcher_if #(
    parameter int DELAY_W   = 8,
    parameter int WIDTH_W   = 4,
    parameter int HOLDOFF_W = 8
) ();
    logic                                  fire;
    logic [DELAY_W-1:0]                    delay_cfg;
    logic [WIDTH_W-1:0]                    width_cfg;
    logic [HOLDOFF_W-1:0]                  holdoff_cfg;
    logic                                  ack_async;
    logic                                  clear_err;
    logic                                  trigger_out;
    logic                                  busy;
    logic                                  dropped;
    logic                                  timeout_err;
    logic [trigger_pkg::TRIG_COUNT_W-1:0]  trig_count;

    modport master (
        output fire, delay_cfg, width_cfg, holdoff_cfg, ack_async, clear_err,
        input  trigger_out, busy, dropped, timeout_err, trig_count
    );

    modport slave (
        input  fire, delay_cfg, width_cfg, holdoff_cfg, ack_async, clear_err,
        output trigger_out, busy, dropped, timeout_err, trig_count
    );
endinterface

// File: rtl/trigger_ack_sync.sv
// N-stage synchronizer bringing the consumer acknowledge into FCLK.
module trigger_ack_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    // Fewer than two stages is not a safe synchronizer; clamp up
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] r_sync;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];
endmodule

// File: rtl/trigger_launcher.sv
// Transmit-side trigger launcher: delayed, width-controlled, level-held
// trigger with 4-phase ack handshake, holdoff, timeout and drop reporting.
module trigger_launcher
    import trigger_pkg::*;
#(
    parameter int DELAY_W     = 8,
    parameter int WIDTH_W     = 4,
    parameter int HOLDOFF_W   = 8,
    parameter int TIMEOUT_W   = 10,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic               FCLK,
    input logic               RST,
    trigger_launcher_if.slave bus
);

    state_t                  r_state;
    logic [DELAY_W-1:0]      r_cnt;
    logic [WIDTH_W-1:0]      r_wcnt;
    logic [WIDTH_W-1:0]      r_width;
    logic [HOLDOFF_W-1:0]    r_hcnt;
    logic [HOLDOFF_W-1:0]    r_holdoff;
    logic [TIMEOUT_W-1:0]    r_tcnt;
    logic                    r_trigger_out;
    logic                    r_busy;
    logic                    r_dropped;
    logic                    r_timeout_err;
    logic [TRIG_COUNT_W-1:0] r_trig_count;

    logic                    w_ack_sync;
    logic [WIDTH_W-1:0]      w_width_eff;
    logic                    w_width_done;
    logic                    w_tmo_max;

    trigger_ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .i_clk (FCLK),
        .i_rst (RST),
        .i_d   (bus.ack_async),
        .o_q   (w_ack_sync)
    );

    // A zero width request still produces a one-cycle pulse
    assign w_width_eff  = (bus.width_cfg == '0) ? WIDTH_W'(1) : bus.width_cfg;
    // Width counts only cycles where the trigger is actually high
    assign w_width_done = r_trigger_out && (r_wcnt == WIDTH_W'(1));
    assign w_tmo_max    = (r_tcnt == {TIMEOUT_W{1'b1}});

    // Launcher FSM with all outputs registered
    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_wcnt        <= '0;
            r_width       <= '0;
            r_hcnt        <= '0;
            r_holdoff     <= '0;
            r_tcnt        <= '0;
            r_trigger_out <= 1'b0;
            r_busy        <= 1'b0;
            r_dropped     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_trig_count  <= '0;
        end else begin
            r_dropped <= bus.fire && (r_state != IDLE);
            // A timeout set later in this block overrides this clear
            if (bus.clear_err) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_trigger_out <= 1'b0;
                    if (bus.fire) begin
                        r_width   <= w_width_eff;
                        r_holdoff <= bus.holdoff_cfg;
                        r_busy    <= 1'b1;
                        if (bus.delay_cfg == '0) begin
                            r_state      <= ASSERT;
                            r_wcnt       <= w_width_eff;
                            r_tcnt       <= '0;
                            r_trig_count <= sat_inc(r_trig_count);
                        end else begin
                            r_state <= DELAY;
                            r_cnt   <= bus.delay_cfg;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                DELAY: begin
                    if (r_cnt <= DELAY_W'(1)) begin
                        r_state      <= ASSERT;
                        r_wcnt       <= r_width;
                        r_tcnt       <= '0;
                        r_trig_count <= sat_inc(r_trig_count);
                    end else begin
                        r_cnt <= r_cnt - DELAY_W'(1);
                    end
                end
                ASSERT: begin
                    if (w_width_done && w_ack_sync) begin
                        r_state       <= RELEASE;
                        r_trigger_out <= 1'b0;
                    end else if (w_tmo_max) begin
                        r_state       <= HOLDOFF;
                        r_hcnt        <= r_holdoff;
                        r_trigger_out <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_trigger_out <= 1'b1;
                        r_tcnt        <= r_tcnt + TIMEOUT_W'(1);
                        if (r_trigger_out && (r_wcnt > WIDTH_W'(1))) begin
                            r_wcnt <= r_wcnt - WIDTH_W'(1);
                        end else begin
                            r_wcnt <= r_wcnt;
                        end
                    end
                end
                RELEASE: begin
                    r_trigger_out <= 1'b0;
                    if (!w_ack_sync) begin
                        if (r_holdoff == '0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= HOLDOFF;
                            r_hcnt  <= r_holdoff;
                        end
                    end else if (w_tmo_max) begin
                        r_state       <= HOLDOFF;
                        r_hcnt        <= r_holdoff;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TIMEOUT_W'(1);
                    end
                end
                HOLDOFF: begin
                    r_trigger_out <= 1'b0;
                    if (r_hcnt <= HOLDOFF_W'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hcnt <= r_hcnt - HOLDOFF_W'(1);
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_trigger_out <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger_out = r_trigger_out;
    assign bus.busy        = r_busy;
    assign bus.dropped     = r_dropped;
    assign bus.timeout_err = r_timeout_err;
    assign bus.trig_count  = r_trig_count;

endmodule

// File: tb/tb_trigger_launcher.sv
// Directed self-checking bench for trigger_launcher.
module tb_trigger_launcher;

    logic FCLK;
    logic RST;
    logic loopback;
    logic ack_man;
    int   errors;
    int   checks;

    typedef struct {
        int d;
        int w;
        int h;
        int exp_rise;
        int exp_high;
        int exp_bfall;
    } vec_t;

    vec_t vt [5];

    trigger_launcher_if #(.DELAY_W(8), .WIDTH_W(4), .HOLDOFF_W(8)) bus_a ();
    trigger_launcher_if #(.DELAY_W(8), .WIDTH_W(4), .HOLDOFF_W(8)) bus_b ();

    assign bus_a.ack_async = loopback ? bus_a.trigger_out : ack_man;

    trigger_launcher #(.DELAY_W(8), .WIDTH_W(4), .HOLDOFF_W(8), .TIMEOUT_W(10), .SYNC_STAGES(2)) dut_a (
        .FCLK (FCLK),
        .RST  (RST),
        .bus  (bus_a)
    );

    trigger_launcher #(.DELAY_W(8), .WIDTH_W(4), .HOLDOFF_W(8), .TIMEOUT_W(4), .SYNC_STAGES(2)) dut_b (
        .FCLK (FCLK),
        .RST  (RST),
        .bus  (bus_b)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Fire once on dut_a and measure rise edge, high cycles and busy-fall edge
    task automatic run_vec(input int d, input int w, input int h,
                           output int rise, output int high, output int bfall);
        rise  = -1;
        high  = 0;
        bfall = -1;
        @(negedge FCLK);
        bus_a.delay_cfg   = 8'(d);
        bus_a.width_cfg   = 4'(w);
        bus_a.holdoff_cfg = 8'(h);
        bus_a.fire        = 1'b1;
        @(posedge FCLK);
        #1;
        bus_a.fire = 1'b0;
        for (int k = 0; k < 200 && bfall < 0; k++) begin
            if (k > 0) begin
                @(posedge FCLK);
                #1;
            end
            if (bus_a.trigger_out) begin
                if (rise < 0) rise = k;
                high++;
            end
            if (!bus_a.busy && bfall < 0) bfall = k;
        end
    endtask

    task automatic wait_idle_a(input string name);
        for (int k = 0; k < 300 && bus_a.busy; k++) begin
            @(posedge FCLK);
            #1;
        end
        check(name, 32'(bus_a.busy), 32'd0);
    endtask

    task automatic wait_idle_b(input string name);
        for (int k = 0; k < 300 && bus_b.busy; k++) begin
            @(posedge FCLK);
            #1;
        end
        check(name, 32'(bus_b.busy), 32'd0);
    endtask

    initial begin
        int rise;
        int high;
        int bfall;
        int rb;
        int fb;
        int bb;

        errors = 0;
        checks = 0;
        // loopback: X = max(D+1+max(W,1), D+4); rise D+1, high X-D-1, busy falls X+3+H
        vt[0] = '{d: 3,  w: 4,  h: 2, exp_rise: 4,  exp_high: 4,  exp_bfall: 13};
        vt[1] = '{d: 0,  w: 0,  h: 0, exp_rise: 1,  exp_high: 3,  exp_bfall: 7};
        vt[2] = '{d: 1,  w: 6,  h: 0, exp_rise: 2,  exp_high: 6,  exp_bfall: 11};
        vt[3] = '{d: 5,  w: 1,  h: 3, exp_rise: 6,  exp_high: 3,  exp_bfall: 15};
        vt[4] = '{d: 10, w: 15, h: 1, exp_rise: 11, exp_high: 15, exp_bfall: 30};

        loopback          = 1'b1;
        ack_man           = 1'b0;
        bus_a.fire        = 1'b0;
        bus_a.delay_cfg   = 8'd0;
        bus_a.width_cfg   = 4'd0;
        bus_a.holdoff_cfg = 8'd0;
        bus_a.clear_err   = 1'b0;
        bus_b.fire        = 1'b0;
        bus_b.delay_cfg   = 8'd0;
        bus_b.width_cfg   = 4'd0;
        bus_b.holdoff_cfg = 8'd0;
        bus_b.clear_err   = 1'b0;
        bus_b.ack_async   = 1'b0;

        RST = 1'b1;
        repeat (3) @(posedge FCLK);
        @(negedge FCLK);
        RST = 1'b0;
        check("rst_trigger", 32'(bus_a.trigger_out), 32'd0);
        check("rst_busy",    32'(bus_a.busy),        32'd0);
        check("rst_dropped", 32'(bus_a.dropped),     32'd0);
        check("rst_tmo",     32'(bus_a.timeout_err), 32'd0);
        check("rst_count",   32'(bus_a.trig_count),  32'd0);

        // Loopback vectors
        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i].d, vt[i].w, vt[i].h, rise, high, bfall);
            check($sformatf("vec%0d_rise", i),  rise,  vt[i].exp_rise);
            check($sformatf("vec%0d_high", i),  high,  vt[i].exp_high);
            check($sformatf("vec%0d_bfall", i), bfall, vt[i].exp_bfall);
        end
        check("vec_count", 32'(bus_a.trig_count), 32'd5);

        // Slow ack: pulse held until two cycles after ack_async rises
        loopback = 1'b0;
        ack_man  = 1'b0;
        @(negedge FCLK);
        bus_a.delay_cfg   = 8'd2;
        bus_a.width_cfg   = 4'd2;
        bus_a.holdoff_cfg = 8'd0;
        bus_a.fire        = 1'b1;
        @(posedge FCLK);
        #1;
        bus_a.fire = 1'b0;
        for (int k = 0; k < 50 && !bus_a.trigger_out; k++) begin
            @(posedge FCLK);
            #1;
        end
        check("slow_rise", 32'(bus_a.trigger_out), 32'd1);
        repeat (20) begin
            @(posedge FCLK);
            #1;
        end
        check("slow_hold", 32'(bus_a.trigger_out), 32'd1);
        ack_man = 1'b1;
        @(posedge FCLK);
        #1;
        check("slow_ack_e0", 32'(bus_a.trigger_out), 32'd1);
        @(posedge FCLK);
        #1;
        check("slow_ack_e1", 32'(bus_a.trigger_out), 32'd1);
        @(posedge FCLK);
        #1;
        check("slow_ack_e2", 32'(bus_a.trigger_out), 32'd0);
        ack_man = 1'b0;
        wait_idle_a("slow_idle");
        check("slow_tmo",   32'(bus_a.timeout_err), 32'd0);
        check("slow_count", 32'(bus_a.trig_count),  32'd6);

        // Fires at edges 0, 2, 10 with only the first accepted
        loopback = 1'b1;
        @(negedge FCLK);
        bus_a.delay_cfg   = 8'd5;
        bus_a.width_cfg   = 4'd1;
        bus_a.holdoff_cfg = 8'd0;
        bus_a.fire        = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(posedge FCLK);
            #1;
            bus_a.fire = ((k + 1) == 2) || ((k + 1) == 10);
            check($sformatf("dropped_e%0d", k), 32'(bus_a.dropped), 32'((k == 2) || (k == 10)));
            if (k == 10) check("busy_e10", 32'(bus_a.busy), 32'd1);
        end
        wait_idle_a("drop_idle");
        check("drop_count", 32'(bus_a.trig_count), 32'd7);

        // Reset while the trigger is high
        @(negedge FCLK);
        bus_a.delay_cfg   = 8'd0;
        bus_a.width_cfg   = 4'd15;
        bus_a.holdoff_cfg = 8'd0;
        bus_a.fire        = 1'b1;
        @(posedge FCLK);
        #1;
        bus_a.fire = 1'b0;
        @(posedge FCLK);
        @(posedge FCLK);
        #1;
        check("rstmid_pre", 32'(bus_a.trigger_out), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("rstmid_trigger", 32'(bus_a.trigger_out), 32'd0);
        check("rstmid_busy",    32'(bus_a.busy),        32'd0);
        check("rstmid_count",   32'(bus_a.trig_count),  32'd0);
        @(negedge FCLK);
        RST = 1'b0;
        run_vec(2, 1, 0, rise, high, bfall);
        check("post_rst_rise",  rise,  32'd3);
        check("post_rst_high",  high,  32'd3);
        check("post_rst_bfall", bfall, 32'd9);
        check("post_rst_count", 32'(bus_a.trig_count), 32'd1);

        // Saturation of the trigger counter
        @(negedge FCLK);
        force dut_a.r_trig_count = 16'hfffe;
        @(negedge FCLK);
        release dut_a.r_trig_count;
        run_vec(0, 0, 0, rise, high, bfall);
        check("sat1_rise",  rise, 32'd1);
        check("sat1_count", 32'(bus_a.trig_count), 32'h0000ffff);
        run_vec(0, 0, 0, rise, high, bfall);
        check("sat2_rise",  rise, 32'd1);
        check("sat2_high",  32'(high >= 1), 32'd1);
        check("sat2_count", 32'(bus_a.trig_count), 32'h0000ffff);

        // Timeout with no ack on the short-timeout instance
        rb = -1;
        fb = -1;
        bb = -1;
        @(negedge FCLK);
        bus_b.delay_cfg   = 8'd0;
        bus_b.width_cfg   = 4'd1;
        bus_b.holdoff_cfg = 8'd2;
        bus_b.fire        = 1'b1;
        @(posedge FCLK);
        #1;
        bus_b.fire = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                @(posedge FCLK);
                #1;
            end
            if (bus_b.trigger_out && rb < 0) rb = k;
            if (!bus_b.trigger_out && rb >= 0 && fb < 0) fb = k;
            if (!bus_b.busy && bb < 0) bb = k;
        end
        check("tmo_rise",  rb, 32'd1);
        check("tmo_fall",  fb, 32'd16);
        check("tmo_bfall", bb, 32'd18);
        check("tmo_err",   32'(bus_b.timeout_err), 32'd1);
        @(negedge FCLK);
        bus_b.clear_err = 1'b1;
        @(posedge FCLK);
        #1;
        bus_b.clear_err = 1'b0;
        check("tmo_clear", 32'(bus_b.timeout_err), 32'd0);

        // Timeout in the same cycle as clear_err: timeout wins
        wait_idle_b("tmo2_idle_pre");
        @(negedge FCLK);
        bus_b.fire = 1'b1;
        @(posedge FCLK);
        #1;
        bus_b.fire = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge FCLK);
            #1;
            if (k == 15) begin
                check("tmo2_pre_err",  32'(bus_b.timeout_err), 32'd0);
                check("tmo2_pre_trig", 32'(bus_b.trigger_out), 32'd1);
                bus_b.clear_err = 1'b1;
            end
            if (k == 16) begin
                bus_b.clear_err = 1'b0;
                check("tmo2_err",  32'(bus_b.timeout_err), 32'd1);
                check("tmo2_trig", 32'(bus_b.trigger_out), 32'd0);
            end
        end
        wait_idle_b("tmo2_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_launcher.md
Name: trigger_launcher

Overview:
- Generates a trigger in the FCLK (5 GHz) domain and delivers it to a slower or asynchronous consumer, which synchronizes it on its side.
- Transmit-side counterpart of the channel trigger synchronizer.
- Drives a glitch-free, registered, level-held trigger with programmable delay and minimum width.
- Holds the trigger until the consumer acknowledges (4-phase req/ack), then applies a holdoff before re-arming.
- Handles timeout and dropped-request accounting.

Parameters:
- DELAY_W, 8, width of delay_cfg (fire-to-trigger delay in FCLK cycles)
- WIDTH_W, 4, width of width_cfg (minimum trigger high time in cycles)
- HOLDOFF_W, 8, width of holdoff_cfg (re-arm dead time in cycles)
- TIMEOUT_W, 10, ack timeout counter width; timeout = 2^TIMEOUT_W - 1 cycles
- SYNC_STAGES, 2, flip-flop stages on ack_async (minimum 2)

Ports:
- FCLK  input  1  fast clock
- RST  input  1  asynchronous, active-high reset
- fire  input  1  single-cycle launch request, FCLK-synchronous
- delay_cfg  input  DELAY_W  delay before assertion, sampled on accept
- width_cfg  input  WIDTH_W  minimum high cycles, sampled on accept; 0 is treated as 1
- holdoff_cfg  input  HOLDOFF_W  cycles spent in HOLDOFF, sampled on accept
- ack_async  input  1  consumer acknowledge, asynchronous to FCLK
- clear_err  input  1  clears timeout_err
- trigger_out  output  1  trigger level to consumer, driven directly from a flop
- busy  output  1  high in any state other than IDLE
- dropped  output  1  one-cycle pulse when fire is rejected
- timeout_err  output  1  sticky ack-timeout flag
- trig_count  output  16  saturating count of trigger assertions

Behaviour:
- Reset: RST=1 forces, asynchronously, state=IDLE, all counters=0, sync chain=0, trigger_out=0, busy=0, dropped=0, timeout_err=0, trig_count=0. Reset mid-operation drops trigger_out immediately; no ack is awaited.
- ack_sync is ack_async passed through SYNC_STAGES flops, which reset to 0.
- IDLE:
  - fire=1 is accepted and the cfg inputs are latched.
  - delay_cfg=0 -> ASSERT next edge.
  - Otherwise -> DELAY with cnt=delay_cfg.
- Latency: fire sampled at edge N -> trigger_out high after edge N+1+delay_cfg.
- DELAY: cnt decrements each cycle; at cnt==1 -> ASSERT.
- ASSERT:
  - trigger_out=1; trig_count increments once on entry and saturates at 0xFFFF.
  - The width counter runs width_cfg cycles (minimum 1).
  - Exit to RELEASE only when the width has elapsed AND ack_sync=1. An early ack does not shorten the pulse.
  - The timeout counter starts on entry. On reaching all-ones with no ack_sync: timeout_err<=1, go to HOLDOFF, trigger_out<=0.
- RELEASE:
  - trigger_out=0.
  - Wait for ack_sync=0, then go to HOLDOFF (or IDLE if holdoff_cfg=0).
  - The timeout also applies here, with the same action.
- HOLDOFF: count holdoff_cfg cycles, then IDLE.
- fire rules:
  - fire is accepted only when state==IDLE at the sampling edge.
  - fire in any other state, including the final HOLDOFF cycle, is ignored and pulses dropped for exactly one cycle.
  - Requests are never queued.
- timeout_err: clear_err=1 clears it. If a new timeout and clear_err occur in the same cycle, the timeout wins.
- Output timing: trigger_out changes only on a clock edge, with no combinational path from inputs. busy is registered and equals (state!=IDLE).
- Counter widths: cnt is DELAY_W wide, the width counter WIDTH_W, holdoff HOLDOFF_W, timeout TIMEOUT_W. No counter wraps; each stops at its terminal value.

Decomposition:
- Shared package trigger_pkg holds:
  - the state enum (IDLE, DELAY, ASSERT, RELEASE, HOLDOFF), 3-bit encoded
  - TRIG_COUNT_W=16
  - the default SYNC_STAGES
- One natural sub-module: trigger_ack_sync, an N-stage synchronizer with active-high asynchronous reset.

Test Plan:
- Loopback ack (ack_async=trigger_out), delay=3, width=4, holdoff=2, fire at edge 0 -> trigger_out rises after edge 4 and stays high exactly 4 cycles; busy falls after the ack low-phase plus 2 holdoff cycles; trig_count=1.
- Slow ack: width=2, ack delayed 20 cycles -> trigger_out stays high until 2 cycles after ack_async rises (SYNC_STAGES=2); no timeout.
- No ack, TIMEOUT_W=4 -> trigger_out falls 15 cycles after assertion and timeout_err=1; clear_err then clears it. Repeat with a timeout coinciding with clear_err -> timeout_err stays 1.
- fire pulses at edges 0, 2 and 10 with delay=5, holdoff=0 and loopback -> dropped pulses at edges 2 and 10 (still busy at 10); trig_count=1.
- Assert RST during ASSERT -> trigger_out=0 asynchronously, before the next FCLK edge; after release, state IDLE and a new fire works normally.
- delay=0, width=0, preload trig_count to 0xFFFF by repeated fires -> trigger 1 cycle after fire; high for at least 1 cycle; trig_count holds at 0xFFFF.
